apb4_protocol_monitor: RTL and testbench

Synthesizable, parametrised APB4 protocol monitor that passively observes one APB bus (master and slave signals), tracks transfer phases with a state machine, and reports violations as sticky flags, a pulse and saturating counters. It extends our APB interface checking with APB4 signals (pstrb, pprot, pslverr), a configurable wait-state timeout and transfer statistics, and it runs in silicon and emulation, not only in simulation. It connects in parallel to any APB master/slave pair; it never drives the bus.

---
 rtl/apb4_protocol_monitor_if.sv | 32 +++
 rtl/apb4_protocol_monitor.sv | 135 +++++++++++++
 tb/tb_apb4_protocol_monitor.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_protocol_monitor_if.sv
// rtl/apb4_protocol_monitor_if.sv - APB4 bus bundle shared by master, slave and passive monitor
interface apb4_protocol_monitor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic                    pslverr;
  logic [DATA_WIDTH-1:0]   prdata;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );

  // The monitor only listens; it never drives any bus signal.
  modport monitor (
    input paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input pready, pslverr, prdata
  );
endinterface

// File: rtl/apb4_protocol_monitor.sv
// rtl/apb4_protocol_monitor.sv - passive APB4 protocol checker with sticky flags and counters
module apb4_protocol_monitor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   i_pclk,
  input  logic                   i_preset_n,
  apb4_protocol_monitor_if.monitor i_bus,
  input  logic                   i_clr,
  output logic [7:0]             o_err_vec,
  output logic                   o_err_pulse,
  output logic [CNT_WIDTH-1:0]   o_err_count,
  output logic [CNT_WIDTH-1:0]   o_xfer_count,
  output logic [1:0]             o_state
);

  localparam int WCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0]       L_TMO     = WCW'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] L_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [2:0]              r_prot;
  logic [DATA_WIDTH/8-1:0] r_strb;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [WCW-1:0]          r_wait_cnt;
  logic [7:0]              r_err_vec;
  logic                    r_err_pulse;
  logic [CNT_WIDTH-1:0]    r_err_count;
  logic [CNT_WIDTH-1:0]    r_xfer_count;

  logic       w_setup;
  logic       w_access;
  logic       w_stall;
  logic       w_compl;
  logic       w_tmo_hit;
  logic [7:0] w_viol;
  logic       w_unused_prdata;

  assign w_setup  = i_bus.psel & ~i_bus.penable;
  assign w_access = i_bus.psel &  i_bus.penable;
  assign w_stall  = w_access & ~i_bus.pready;
  assign w_compl  = w_access &  i_bus.pready;
  assign w_unused_prdata = ^i_bus.prdata;

  // The wait counter saturates at L_TMO, so this matches exactly once per transfer.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && w_stall && ((r_wait_cnt + 1'b1) == L_TMO);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_setup) w_next = S_SETUP;
      end
      S_SETUP, S_WAIT: begin
        if (w_setup)      w_next = S_SETUP;
        else if (w_stall) w_next = S_WAIT;
        else              w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_viol    = 8'h00;
    w_viol[0] = (r_state == S_SETUP) && !w_access;
    w_viol[1] = (r_state == S_IDLE) && w_access;
    w_viol[2] = (r_state != S_IDLE) && w_access &&
                ((i_bus.paddr != r_addr) || (i_bus.pwrite != r_write) || (i_bus.pprot != r_prot));
    w_viol[3] = (r_state != S_IDLE) && w_access && r_write &&
                ((i_bus.pwdata != r_wdata) || (i_bus.pstrb != r_strb));
    w_viol[4] = (r_state == S_WAIT) && !w_access;
    w_viol[5] = w_tmo_hit;
    w_viol[6] = w_setup && !i_bus.pwrite && (|i_bus.pstrb);
    w_viol[7] = i_bus.pslverr && !w_compl;
  end

  always_ff @(posedge i_pclk or negedge i_preset_n) begin
    if (!i_preset_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_prot       <= '0;
      r_strb       <= '0;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
      r_err_vec    <= 8'h00;
      r_err_pulse  <= 1'b0;
      r_err_count  <= '0;
      r_xfer_count <= '0;
    end else begin
      r_state     <= w_next;
      r_err_pulse <= |w_viol;
      if (w_setup) begin
        r_addr     <= i_bus.paddr;
        r_write    <= i_bus.pwrite;
        r_prot     <= i_bus.pprot;
        r_strb     <= i_bus.pstrb;
        r_wdata    <= i_bus.pwdata;
        r_wait_cnt <= '0;
      end else if (w_stall && (r_wait_cnt != L_TMO)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      // Clear takes effect first, so this cycle's events land on zeroed state.
      if (i_clr) begin
        r_err_vec    <= w_viol;
        r_err_count  <= CNT_WIDTH'(|w_viol);
        r_xfer_count <= CNT_WIDTH'(w_compl);
      end else begin
        r_err_vec <= r_err_vec | w_viol;
        if ((|w_viol) && (r_err_count != L_CNT_MAX))
          r_err_count <= r_err_count + 1'b1;
        if (w_compl && (r_xfer_count != L_CNT_MAX))
          r_xfer_count <= r_xfer_count + 1'b1;
      end
    end
  end

  assign o_err_vec    = r_err_vec;
  assign o_err_pulse  = r_err_pulse;
  assign o_err_count  = r_err_count;
  assign o_xfer_count = r_xfer_count;
  assign o_state      = r_state;

endmodule

// File: tb/tb_apb4_protocol_monitor.sv
// tb/tb_apb4_protocol_monitor.sv - randomized and directed bench for apb4_protocol_monitor
module tb_apb4_protocol_monitor;

  logic clk;
  logic rst_n;
  logic clr;
  bit   rnd_mode;

  int checks = 0;
  int errors = 0;

  apb4_protocol_monitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  logic [7:0] o_vec   [3];
  logic       o_pulse [3];
  logic [7:0] o_ecnt  [3];
  logic [7:0] o_xcnt  [3];
  logic [1:0] o_st    [3];

  apb4_protocol_monitor #(.TIMEOUT_CYCLES(16)) dut_t16 (
    .i_pclk(clk), .i_preset_n(rst_n), .i_bus(bus), .i_clr(clr),
    .o_err_vec(o_vec[0]), .o_err_pulse(o_pulse[0]), .o_err_count(o_ecnt[0]),
    .o_xfer_count(o_xcnt[0]), .o_state(o_st[0]));

  apb4_protocol_monitor #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .i_pclk(clk), .i_preset_n(rst_n), .i_bus(bus), .i_clr(clr),
    .o_err_vec(o_vec[1]), .o_err_pulse(o_pulse[1]), .o_err_count(o_ecnt[1]),
    .o_xfer_count(o_xcnt[1]), .o_state(o_st[1]));

  apb4_protocol_monitor #(.TIMEOUT_CYCLES(0)) dut_t0 (
    .i_pclk(clk), .i_preset_n(rst_n), .i_bus(bus), .i_clr(clr),
    .o_err_vec(o_vec[2]), .o_err_pulse(o_pulse[2]), .o_err_count(o_ecnt[2]),
    .o_xfer_count(o_xcnt[2]), .o_state(o_st[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Reference model: tracks whether a transfer is open and whether the last cycle was its SETUP.
  bit          m_open  [3];
  bit          m_js    [3];
  int          m_waits [3];
  logic [7:0]  m_vec   [3];
  bit          m_pulse [3];
  int          m_ecnt  [3];
  int          m_xcnt  [3];
  logic [31:0] c_addr, c_data;
  logic        c_write;
  logic [3:0]  c_strb;
  logic [2:0]  c_prot;

  function automatic int tmo(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 0;
  endfunction

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  logic [7:0] v;
  bit is_set, is_acc, stall, done, addr_bad, data_bad;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_open[k] <= 0; m_js[k] <= 0; m_waits[k] <= 0; m_vec[k] <= 8'h00;
        m_pulse[k] <= 0; m_ecnt[k] <= 0; m_xcnt[k] <= 0;
      end
      c_addr <= '0; c_data <= '0; c_write <= 1'b0; c_strb <= '0; c_prot <= '0;
    end else begin
      is_set   = bus.psel && !bus.penable;
      is_acc   = bus.psel && bus.penable;
      stall    = is_acc && !bus.pready;
      done     = is_acc && bus.pready;
      addr_bad = (bus.paddr != c_addr) || (bus.pwrite != c_write) || (bus.pprot != c_prot);
      data_bad = c_write && ((bus.pwdata != c_data) || (bus.pstrb != c_strb));
      for (int k = 0; k < 3; k++) begin
        v    = 8'h00;
        v[0] = m_js[k] && !is_acc;
        v[1] = !m_open[k] && is_acc;
        v[2] = m_open[k] && is_acc && addr_bad;
        v[3] = m_open[k] && is_acc && data_bad;
        v[4] = m_open[k] && !m_js[k] && !is_acc;
        v[5] = (tmo(k) != 0) && stall && (m_waits[k] + 1 == tmo(k));
        v[6] = is_set && !bus.pwrite && (bus.pstrb != 4'h0);
        v[7] = bus.pslverr && !done;
        m_vec[k]   <= (clr ? 8'h00 : m_vec[k]) | v;
        m_pulse[k] <= (v != 8'h00);
        m_ecnt[k]  <= (clr ? 0 : m_ecnt[k]) + ((v != 8'h00) ? 1 : 0);
        m_xcnt[k]  <= (clr ? 0 : m_xcnt[k]) + (done ? 1 : 0);
        m_open[k]  <= is_set || (stall && m_open[k]);
        m_js[k]    <= is_set;
        m_waits[k] <= is_set ? 0 : (stall ? m_waits[k] + 1 : m_waits[k]);
      end
      if (is_set) begin
        c_addr <= bus.paddr; c_data <= bus.pwdata; c_write <= bus.pwrite;
        c_strb <= bus.pstrb; c_prot <= bus.pprot;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("err_vec",    k, 32'(o_vec[k]),   32'(m_vec[k]));
      chk("err_pulse",  k, 32'(o_pulse[k]), 32'(m_pulse[k]));
      chk("err_count",  k, 32'(o_ecnt[k]),  32'(sat(m_ecnt[k])));
      chk("xfer_count", k, 32'(o_xcnt[k]),  32'(sat(m_xcnt[k])));
      chk("state",      k, 32'(o_st[k]),    !m_open[k] ? 32'd0 : (m_js[k] ? 32'd1 : 32'd2));
    end
  end

  task automatic step();
    if (rnd_mode) clr = ($urandom_range(0, 49) == 0);
    @(posedge clk);
    #2;
  endtask

  task automatic drv_idle();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0;
  endtask

  task automatic drv_setup(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input logic [2:0] p);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwrite = w;
    bus.pstrb = s; bus.pwdata = d; bus.pprot = p; bus.pready = 1'b0; bus.pslverr = 1'b0;
  endtask

  task automatic drv_acc(input logic rdy, input logic err);
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pready = rdy; bus.pslverr = err;
  endtask

  task automatic do_clr();
    drv_idle(); clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic rand_xfer();
    int nw;
    bit abandon;
    if ($urandom_range(0, 149) == 0) begin
      rst_n = 1'b0; step(); rst_n = 1'b1;
    end
    repeat ($urandom_range(0, 2)) begin
      drv_idle(); bus.pslverr = ($urandom_range(0, 29) == 0); step();
    end
    if ($urandom_range(0, 19) == 0) begin
      drv_acc(1'($urandom_range(0, 1)), 1'b0); step();
    end
    bus.pwrite = 1'($urandom_range(0, 1));
    drv_setup(32'($urandom_range(0, 3)) << 2, bus.pwrite,
              (bus.pwrite || $urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
              $urandom, 3'($urandom));
    step();
    nw      = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(0, 5);
    abandon = ($urandom_range(0, 11) == 0);
    for (int i = 0; i < nw; i++) begin
      drv_acc(1'b0, $urandom_range(0, 9) == 0);
      case ($urandom_range(0, 39))
        0: bus.paddr  = bus.paddr ^ 32'h4;
        1: bus.pwdata = bus.pwdata ^ 32'h1;
        2: bus.pprot  = bus.pprot ^ 3'h1;
        3: bus.pstrb  = bus.pstrb ^ 4'h2;
        default: ;
      endcase
      step();
    end
    if (abandon) begin
      if ($urandom_range(0, 1) == 0) drv_idle();
      else begin bus.penable = 1'b0; bus.pslverr = 1'b0; end
    end else begin
      drv_acc(1'b1, $urandom_range(0, 7) == 0);
    end
    step();
  endtask

  initial begin
    rnd_mode = 0;
    clr      = 1'b0;
    rst_n    = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0;
    bus.pwrite = 1'b0; bus.prdata = '0;
    drv_idle();
    step(); step();
    chk("rst_vec", 0, 32'(o_vec[0]), 32'h0);
    chk("rst_cnt", 0, 32'(o_ecnt[0]), 32'h0);
    chk("rst_state", 0, 32'(o_st[0]), 32'h0);
    rst_n = 1'b1;
    step();

    // Legal write with two wait states.
    drv_setup(32'h10, 1'b1, 4'hF, 32'hA5A5_0001, 3'h0); step();
    chk("w_state1", 0, 32'(o_st[0]), 32'd1);
    drv_acc(1'b0, 1'b0); step();
    chk("w_state2", 0, 32'(o_st[0]), 32'd2);
    drv_acc(1'b0, 1'b0); step();
    chk("w_state3", 0, 32'(o_st[0]), 32'd2);
    drv_acc(1'b1, 1'b0); step();
    chk("w_state4", 0, 32'(o_st[0]), 32'd0);
    chk("w_vec", 0, 32'(o_vec[0]), 32'h0);
    chk("w_xfer", 0, 32'(o_xcnt[0]), 32'd1);
    do_clr();
    chk("clr_xfer", 0, 32'(o_xcnt[0]), 32'd0);

    // Address changes between SETUP and ACCESS.
    drv_setup(32'h10, 1'b0, 4'h0, 32'h0, 3'h0); step();
    bus.paddr = 32'h14; drv_acc(1'b1, 1'b0); step();
    chk("addr_vec", 0, 32'(o_vec[0]), 32'h04);
    chk("addr_pulse", 0, 32'(o_pulse[0]), 32'd1);
    chk("addr_cnt", 0, 32'(o_ecnt[0]), 32'd1);
    drv_idle(); step();
    chk("addr_pulse_off", 0, 32'(o_pulse[0]), 32'd0);
    do_clr();

    // ACCESS from IDLE, then abandon in WAIT.
    drv_acc(1'b1, 1'b0); step();
    chk("orph_vec", 0, 32'(o_vec[0]), 32'h02);
    drv_idle(); step();
    drv_setup(32'h20, 1'b1, 4'h3, 32'h1234, 3'h2); step();
    drv_acc(1'b0, 1'b0); step();
    drv_idle(); step();
    chk("aband_vec", 0, 32'(o_vec[0]), 32'h12);
    chk("aband_cnt", 0, 32'(o_ecnt[0]), 32'd2);
    do_clr();

    // Timeout at 4 stalls reported once; disabled instance stays quiet.
    drv_setup(32'h30, 1'b1, 4'hF, 32'h55, 3'h1); step();
    for (int i = 1; i <= 6; i++) begin
      drv_acc(1'b0, 1'b0); step();
      if (i == 3) chk("tmo_early", 1, 32'(o_vec[1]), 32'h00);
      if (i == 4) chk("tmo_vec", 1, 32'(o_vec[1]), 32'h20);
    end
    chk("tmo_cnt", 1, 32'(o_ecnt[1]), 32'd1);
    chk("tmo_off", 2, 32'(o_vec[2]), 32'h00);
    chk("tmo_16", 0, 32'(o_vec[0]), 32'h00);
    drv_acc(1'b1, 1'b0); step();
    do_clr();

    // Read with strobes, slave error during wait, then error completion.
    drv_setup(32'h40, 1'b0, 4'h3, 32'h0, 3'h0); step();
    drv_acc(1'b0, 1'b1); step();
    drv_acc(1'b1, 1'b1); step();
    chk("rd_vec", 0, 32'(o_vec[0]), 32'hC0);
    chk("rd_cnt", 0, 32'(o_ecnt[0]), 32'd2);
    chk("rd_xfer", 0, 32'(o_xcnt[0]), 32'd1);
    do_clr();

    // Back-to-back transfers saturate the transfer counter.
    for (int i = 0; i < 300; i++) begin
      drv_setup(32'h50, 1'b1, 4'hF, 32'(i), 3'h0); step();
      drv_acc(1'b1, 1'b0); step();
    end
    chk("sat_xfer", 0, 32'(o_xcnt[0]), 32'd255);
    chk("sat_vec", 0, 32'(o_vec[0]), 32'h00);
    drv_setup(32'h50, 1'b1, 4'hF, 32'h9, 3'h0); step();
    clr = 1'b1; drv_acc(1'b1, 1'b0); step(); clr = 1'b0;
    chk("clr_compl", 0, 32'(o_xcnt[0]), 32'd1);

    // Reset mid-WAIT, then the held ACCESS is judged from IDLE.
    drv_setup(32'h60, 1'b1, 4'hF, 32'h7, 3'h0); step();
    drv_acc(1'b0, 1'b0); step();
    chk("pre_rst_state", 0, 32'(o_st[0]), 32'd2);
    rst_n = 1'b0; #1;
    chk("mid_rst_state", 0, 32'(o_st[0]), 32'd0);
    chk("mid_rst_xfer", 0, 32'(o_xcnt[0]), 32'd0);
    step();
    rst_n = 1'b1; drv_acc(1'b1, 1'b0); step();
    chk("post_rst_vec", 0, 32'(o_vec[0]), 32'h02);
    drv_idle(); step();

    rnd_mode = 1;
    for (int n = 0; n < 400; n++) rand_xfer();
    rnd_mode = 0;
    clr = 1'b0;
    drv_idle(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
